// File: rtl/rc_state_predictor.sv
// rc_state_predictor
// -------------------------------------------------------------------------
// Time-multiplexed RC-branch state predictor for the EKF prediction stage.
// For every branch k it computes
//     x_p[k] = sat(a[k]*x[k] + b[k]*i_b)
// with a single shared multiplier pair, one branch every two cycles
// (MUL cycle: products registered, ADD cycle: align/sum/clamp/write back).
//
// Ports
//   clk    in   rising-edge clock
//   n_rst  in   asynchronous reset, active-high (1 = in reset)
//   start  in   run request, only looked at while idle
//   i_b    in   battery current, signed Q(INT_I.FLT_I)
//   x_in   in   previous RC states, branch k at [k*DW +: DW]
//   a_in   in   per-branch decay coefficient, same packing
//   b_in   in   per-branch input gain, same packing
//   busy   out  registered; high for the 2*N_CH+1 cycles of a run
//   done   out  registered one-cycle pulse; x_p and sat are valid
//   x_p    out  predicted states, registered, same packing as x_in
//   sat    out  per-branch saturation flags of the last run
//
// Optional feature
//   RC_PRED_ROUND_EN : when defined, half an output LSB is added before the
//                      final right shift (round-half-up); saturation is then
//                      evaluated on the rounded value. Undefined: plain
//                      truncation toward -inf, no rounding adder.
// -------------------------------------------------------------------------
module rc_state_predictor #(
  parameter int N_CH  = 2,
  parameter int DW    = 24,
  parameter int DW_I  = 5,
  parameter int INT_I = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [DW_I-1:0]      i_b,
  input  logic [N_CH*DW-1:0]   x_in,
  input  logic [N_CH*DW-1:0]   a_in,
  input  logic [N_CH*DW-1:0]   b_in,
  output logic                 busy,
  output logic                 done,
  output logic [N_CH*DW-1:0]   x_p,
  output logic [N_CH-1:0]      sat
);

  localparam int FLT_I = DW_I - 1 - INT_I;
  localparam int PAW   = 2 * DW;          // a*x product width
  localparam int PBW   = DW + DW_I;       // b*i_b product width
  localparam int SW    = 2 * DW + DW_I;   // accumulation width
  localparam int SH_B  = DW - 1 - FLT_I;  // aligns pb to pa's fraction point
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_r, state_nx;
  logic [CW-1:0]       ch_r;
  logic [DW_I-1:0]     ib_r;
  logic [N_CH*DW-1:0]  x_r, a_r, b_r;
  logic [PAW-1:0]      pa_r;
  logic [PBW-1:0]      pb_r;

  logic [DW-1:0]       a_sel_s, x_sel_s, b_sel_s;
  logic [PAW-1:0]      pa_s;
  logic [PBW-1:0]      pb_s;
  logic [SW-1:0]       sum_s, sum_rnd_s;
  logic signed [SW-1:0] sh_s;
  logic [DW:0]         clamp_s;           // {sat flag, clamped value}
  logic                last_ch_s;

  // Clamp a wide signed value to DW bits; MSB of the result is the sat flag.
  function automatic logic [DW:0] clamp_fn(input logic signed [SW-1:0] v);
    logic [SW-DW:0] top;
    top = v[SW-1:DW-1];
    // In range when every bit above the DW-bit sign position matches it.
    if (top == {(SW-DW+1){1'b0}} || top == {(SW-DW+1){1'b1}}) begin
      return {1'b0, v[DW-1:0]};
    end else if (v[SW-1]) begin
      return {1'b1, 1'b1, {(DW-1){1'b0}}};
    end else begin
      return {1'b1, 1'b0, {(DW-1){1'b1}}};
    end
  endfunction

  // Operand mux for the branch currently being processed.
  assign a_sel_s = a_r[int'(ch_r)*DW +: DW];
  assign x_sel_s = x_r[int'(ch_r)*DW +: DW];
  assign b_sel_s = b_r[int'(ch_r)*DW +: DW];

  // Operands are sign-extended to the product width so an unsigned multiply
  // truncated to that width yields the exact two's-complement product.
  assign pa_s = {{DW{a_sel_s[DW-1]}}, a_sel_s} * {{DW{x_sel_s[DW-1]}}, x_sel_s};
  assign pb_s = {{DW_I{b_sel_s[DW-1]}}, b_sel_s} * {{DW{ib_r[DW_I-1]}}, ib_r};

  assign sum_s = {{(SW-PAW){pa_r[PAW-1]}}, pa_r}
               + ({{(SW-PBW){pb_r[PBW-1]}}, pb_r} << SH_B);

`ifdef RC_PRED_ROUND_EN
  assign sum_rnd_s = sum_s + ({{(SW-1){1'b0}}, 1'b1} << (DW-2));
`else
  assign sum_rnd_s = sum_s;
`endif

  assign sh_s      = $signed(sum_rnd_s) >>> (DW-1);
  assign clamp_s   = clamp_fn(sh_s);
  assign last_ch_s = (ch_r == CW'(N_CH-1));

  // FSM state register.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx = MUL;
        end else begin
          state_nx = IDLE;
        end
      end
      MUL: state_nx = ADD;
      ADD: begin
        if (last_ch_s) begin
          state_nx = DONE;
        end else begin
          state_nx = MUL;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, product registers, branch counter and result write-back.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      ch_r <= {CW{1'b0}};
      ib_r <= {DW_I{1'b0}};
      x_r  <= {(N_CH*DW){1'b0}};
      a_r  <= {(N_CH*DW){1'b0}};
      b_r  <= {(N_CH*DW){1'b0}};
      pa_r <= {PAW{1'b0}};
      pb_r <= {PBW{1'b0}};
      x_p  <= {(N_CH*DW){1'b0}};
      sat  <= {N_CH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            ib_r <= i_b;
            x_r  <= x_in;
            a_r  <= a_in;
            b_r  <= b_in;
            ch_r <= {CW{1'b0}};
            sat  <= {N_CH{1'b0}};
          end
        end
        MUL: begin
          pa_r <= pa_s;
          pb_r <= pb_s;
        end
        ADD: begin
          x_p[int'(ch_r)*DW +: DW] <= clamp_s[DW-1:0];
          sat[ch_r]                <= clamp_s[DW];
          if (!last_ch_s) begin
            ch_r <= ch_r + CW'(1'b1);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Registered status outputs; done lands in the cycle after the DONE state.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_r != IDLE);
      done <= (state_r == DONE);
    end
  end

endmodule

// File: tb/tb_rc_state_predictor.sv
// Directed self-checking bench for rc_state_predictor (N_CH=2, DW=24,
// DW_I=5, INT_I=4). Expected values are hand-computed Q0.23 results.
module tb_rc_state_predictor;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [4:0]  i_b;
  logic [47:0] x_in, a_in, b_in;
  logic        busy, done;
  logic [47:0] x_p;
  logic [1:0]  sat;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] mid_xp;
  logic [23:0] rnd_exp;

  rc_state_predictor #(.N_CH(2), .DW(24), .DW_I(5), .INT_I(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .start (start),
    .i_b   (i_b),
    .x_in  (x_in),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .x_p   (x_p),
    .sat   (sat)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [23:0] a0, input logic [23:0] x0, input logic [23:0] b0,
                         input logic [23:0] a1, input logic [23:0] x1, input logic [23:0] b1,
                         input logic [4:0] ib);
    a_in = {a1, a0};
    x_in = {x1, x0};
    b_in = {b1, b0};
    i_b  = ib;
  endtask

  // One start pulse accepted at edge T; c counts edges after T. Samples #1
  // after each edge; captures x_p after edge T+3 (branch 0 written only).
  task automatic run(input string tag, input logic [47:0] exp_xp, input logic [1:0] exp_sat,
                     output logic [47:0] mid);
    int done_at;
    int n_done;
    done_at = 0;
    n_done  = 0;
    mid     = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) check_eq({tag, " busy_c1"}, {63'd0, busy}, 64'd1);
      if (c == 3) mid = x_p;
      if (done) begin
        n_done++;
        if (done_at == 0) done_at = c;
      end
    end
    check_eq({tag, " latency"}, done_at, 64'd5);
    check_eq({tag, " done_cnt"}, n_done, 64'd1);
    check_eq({tag, " x_p"}, {16'd0, x_p}, {16'd0, exp_xp});
    check_eq({tag, " sat"}, {62'd0, sat}, {62'd0, exp_sat});
    check_eq({tag, " busy_end"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
`ifdef RC_PRED_ROUND_EN
    rnd_exp = 24'h000001;
`else
    rnd_exp = 24'h000000;
`endif
    n_rst = 1'b1;
    start = 1'b0;
    set_ops(24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst busy", {63'd0, busy}, 64'd0);
    check_eq("rst done", {63'd0, done}, 64'd0);
    check_eq("rst x_p", {16'd0, x_p}, 64'd0);
    check_eq("rst sat", {62'd0, sat}, 64'd0);
    n_rst = 1'b0;
    @(posedge clk); #1;

    // 1: 0.5*0.5 + 0.25*2 = 0.75
    set_ops(24'h400000, 24'h400000, 24'h200000, 24'h400000, 24'h400000, 24'h200000, 5'd2);
    run("t1", 48'h600000_600000, 2'b00, mid_xp);

    // 3: rounding of 2^-24; branch 1 keeps the previous-run value mid-run
    set_ops(24'h000001, 24'h400000, 24'h0, 24'h000001, 24'h400000, 24'h0, 5'd0);
    run("t3", {rnd_exp, rnd_exp}, 2'b00, mid_xp);
    check_eq("t3 mid x_p", {16'd0, mid_xp}, {16'd0, 24'h600000, rnd_exp});

    // 2a: positive overflow on both branches
    set_ops(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 5'd15);
    run("t2a", 48'h7FFFFF_7FFFFF, 2'b11, mid_xp);

    // 2b: branch 0 negative overflow (-16), branch 1 in range (0.25)
    set_ops(24'h0, 24'h7FFFFF, 24'h7FFFFF, 24'h400000, 24'h400000, 24'h0, 5'b10000);
    run("t2b", 48'h200000_800000, 2'b01, mid_xp);

    // sat flags cleared on the next accepted start
    set_ops(24'h400000, 24'h400000, 24'h200000, 24'h400000, 24'h400000, 24'h200000, 5'd2);
    run("t1b", 48'h600000_600000, 2'b00, mid_xp);

    // 4: start while busy is ignored; input changes after acceptance are ignored
    begin
      int n_done;
      n_done = 0;
      set_ops(24'h400000, 24'h400000, 24'h200000, 24'h400000, 24'h400000, 24'h200000, 5'd2);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
        @(posedge clk); #1;
        if (c == 2) start = 1'b1;
        if (c == 3) begin
          start = 1'b0;
          set_ops(24'h7FFFFF, 24'h123456, 24'h7FFFFF, 24'h7FFFFF, 24'h654321, 24'h7FFFFF, 5'd7);
        end
        if (done) n_done++;
      end
      check_eq("t4 done_cnt", n_done, 64'd1);
      check_eq("t4 x_p", {16'd0, x_p}, {16'd0, 48'h600000_600000});
    end

    // 5: reset mid-run clears outputs at once, no done; next run is normal
    begin
      int n_done;
      n_done = 0;
      set_ops(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 5'd15);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk); #1;
      end
      n_rst = 1'b1;
      #1;
      check_eq("t5 busy", {63'd0, busy}, 64'd0);
      check_eq("t5 done", {63'd0, done}, 64'd0);
      check_eq("t5 x_p", {16'd0, x_p}, 64'd0);
      check_eq("t5 sat", {62'd0, sat}, 64'd0);
      @(posedge clk); #1;
      n_rst = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk); #1;
        if (done) n_done++;
      end
      check_eq("t5 no_done", n_done, 64'd0);
      check_eq("t5 idle busy", {63'd0, busy}, 64'd0);
      set_ops(24'h400000, 24'h400000, 24'h200000, 24'h400000, 24'h400000, 24'h200000, 5'd2);
      run("t5r", 48'h600000_600000, 2'b00, mid_xp);
    end

    // 6: start held high for three runs; done every 6 cycles
    begin
      int n_done;
      int d_at[3];
      n_done = 0;
      d_at = '{0, 0, 0};
      set_ops(24'h100000, 24'h400000, 24'h0, 24'h200000, 24'h400000, 24'h0, 5'd0);
      start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 24; c++) begin
        @(posedge clk); #1;
        if (c == 12) start = 1'b0;
        if (done) begin
          if (n_done < 3) d_at[n_done] = c;
          n_done++;
        end
      end
      check_eq("t6 done_cnt", n_done, 64'd3);
      check_eq("t6 done0", d_at[0], 64'd5);
      check_eq("t6 done1", d_at[1], 64'd11);
      check_eq("t6 done2", d_at[2], 64'd17);
      check_eq("t6 x_p", {16'd0, x_p}, {16'd0, 48'h100000_080000});
      check_eq("t6 sat", {62'd0, sat}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rc_state_predictor.md
Name: rc_state_predictor

Overview:
Time-multiplexed, parametrised successor to the single-branch RC-voltage predictor in the EKF datapath. For each of N_CH RC branches it computes x_p[k] = sat(a[k]*x[k] + b[k]*i_b) using one shared multiplier pair. It runs under a start/done handshake and registers every result. Its outputs feed the EKF prediction stage: Vt estimate and covariance update.

Parameters:
N_CH, 2, number of RC branches (1..8)
DW, 24, width of x, a, b, x_p; signed Q(1 sign, 0 int, DW-1 frac)
DW_I, 5, width of i_b (signed)
INT_I, 4, integer bits of i_b; FLT_I = DW_I-1-INT_I, must satisfy FLT_I <= DW-1

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  reset; asynchronous, active-high (1 = reset asserted)
start  in  1  request; sampled only in IDLE
i_b  in  DW_I  battery current, signed Q(INT_I.FLT_I)
x_in  in  N_CH*DW  previous RC states; channel k at bits [k*DW +: DW]
a_in  in  N_CH*DW  per-branch decay coefficient (a4-style)
b_in  in  N_CH*DW  per-branch input gain (b2-style)
busy  out  1  high from the cycle after start is accepted until DONE is left
done  out  1  one-cycle pulse; x_p and sat are valid
x_p  out  N_CH*DW  predicted states, registered, same packing as x_in
sat  out  N_CH  per-channel saturation flag for the last run

Behaviour:
- Reset, async: state=IDLE, ch=0, busy=0, done=0, x_p=0, sat=0, all operand registers 0.
- FSM states: IDLE, MUL, ADD, DONE.
- IDLE: when start=1, latch i_b, x_in, a_in, b_in into operand registers, set ch=0, clear sat, go to MUL. Otherwise stay.
- MUL: register pa = a[ch]*x[ch] (2*(DW-1) frac) and pb = b[ch]*i_b (DW-1+FLT_I frac). Go to ADD.
- ADD: sum = pa + (pb << (DW-1-FLT_I)), using a sign-extended width of 2*DW+DW_I. Shift right arithmetically by DW-1. Clamp to [-2^(DW-1), 2^(DW-1)-1].
  - Write the result to x_p[ch]; set sat[ch]=1 if clamped.
  - If ch==N_CH-1 go to DONE; else ch++ and go to MUL.
- DONE: done=1 for this single cycle, then go to IDLE. busy is high in MUL, ADD, DONE and low in IDLE.
- Latency: start accepted at edge T; done is high in the cycle beginning at edge T+2*N_CH+1.
- start while busy: ignored, no queueing. Inputs may change freely after acceptance.
- start held high continuously: a new run begins on the edge after DONE. The IDLE cycle is mandatory, so throughput is one run per 2*N_CH+2 cycles.
- x_p holds its values between runs. Channels not yet written in the current run keep their previous-run values.
- Reset mid-run: immediate return to IDLE with all outputs 0; no done pulse.
- Default rounding is truncation toward -inf (plain arithmetic shift).

Optional Feature:
Macro RC_PRED_ROUND_EN.
- Defined: add 2^(DW-2) to sum before the shift, giving round-half-up. Saturation is evaluated after rounding.
- Undefined: truncation only. No rounding adder is synthesised.

Test Plan:
1. N_CH=2, DW=24, DW_I=5, INT_I=4. Inputs: a=0x400000, x=0x400000, b=0x200000, i_b=5'd2 on both channels. Pulse start -> done at T+5, x_p = {0x600000, 0x600000}, sat=2'b00.
2. a=0x7FFFFF, x=0x7FFFFF, b=0x7FFFFF, i_b=5'd15 -> x_p[k]=0x7FFFFF, sat=2'b11. Separately, a=0, b=0x7FFFFF, i_b=5'b10000 (-16) -> x_p=0x800000, sat set.
3. Rounding: a=0x000001, x=0x400000, b=0, i_b=0 -> x_p=0x000000 without RC_PRED_ROUND_EN; x_p=0x000001 with it.
4. Second start pulse during busy, then changing x_in mid-run -> no extra done; results computed from the inputs latched at acceptance.
5. Assert n_rst at T+3 of a run -> outputs 0 in the same cycle, FSM in IDLE, no done. A following start completes normally with correct values.
6. start held high for 3 runs with distinct a values per channel (0x100000, 0x200000), x=0x400000, b=0 -> done pulses every 6 cycles, x_p = {0x100000, 0x080000}.
